tetris_ctrl: RTL and testbench
==============================

# tetris_ctrl

Top-level game sequencer for the tetris datapath `dp`. It owns the game state register and drives the 3-bit `state`/`old_state` encoding into the datapath. It holds the registered board, piece, location and rotation that feed back into the datapath. It turns player button requests and a gravity timer into one-cycle MOVE actions, tracks landing, clear and game-over, and keeps the line score.

## Interface
- `DROP_TICKS`, default 16: WAIT cycles between gravity drops; legal range 2..255.
- `SCORE_W`, default 8: score counter width.

- `clka`  in  1  system clock; all logic on rising edge.
- `restart`  in  1  synchronous, active-high reset.
- `btn_valid`  in  1  player request valid.
- `btn_move`  in  2  request code: 1=left, 2=right, 3=rotate; 0 is ignored (not accepted).
- `btn_ready`  out  1  controller can accept a request this cycle.
- `state`  out  3  to `dp.state`. Encoding: GEN=000, MOVE=001, LAND=010, CLEAR=011, NEWBOARD=100, GAMEOVER=101, WAIT=110.
- `old_state`  out  3  to `dp.old_state`; value of `state` in the previous cycle.
- `move`  out  2  to `dp.move`; 0=gravity drop, 1/2/3 as `btn_move`.
- `board_q`  out  32  to `dp.board_in`.
- `piece_q`  out  2  to `dp.curr_piece_in`.
- `location_q`  out  5  to `dp.location_in`.
- `rotation_q`  out  2  to `dp.rotation_in`.
- `dp_board`, `dp_piece`, `dp_location`, `dp_rotation`  in  32/2/5/2  datapath results.
- `dp_touched`  in  1  datapath reports the piece rests on the stack or the floor.
- `dp_error`  in  1  datapath reports that the spawn overlaps the stack.
- `game_over`  out  1  high while in GAMEOVER.
- `score`  out  SCORE_W  cleared-line count, saturating.

## Operation
- All outputs are registered.
- Reset values:
  - `state`=NEWBOARD, `old_state`=NEWBOARD.
  - `move`=0, `board_q`=0, `piece_q`=0, `location_q`=5'd2, `rotation_q`=0.
  - `score`=0, `game_over`=0, `btn_ready`=0.
  - Drop counter=0.
- Board layout: bit `r*4+c`, with row 0 at the top and 8 rows of 4 columns. A row is full when its 4 bits are all 1.
- NEWBOARD (1 cycle):
  - Latch `board_q`<=`dp_board`, `piece_q`<=0, `location_q`<=2, `rotation_q`<=0.
  - Next state: GEN.
- GEN (1 cycle):
  - Latch `piece_q`<=`dp_piece`, `board_q`<=`dp_board`, `location_q`<=2, `rotation_q`<=0.
  - Clear the drop counter.
  - Next state: GAMEOVER if `dp_error`, else WAIT.
- WAIT:
  - `btn_ready`=1.
  - If `btn_valid` is high and `btn_move`!=0: latch `move`<=`btn_move` and go to MOVE.
  - Else if the drop counter is DROP_TICKS-1: latch `move`<=0, clear the counter and go to MOVE.
  - Else increment the counter.
  - A button request has priority over gravity. When both are due in the same cycle, the counter holds at DROP_TICKS-1 and the gravity drop fires on the next WAIT cycle.
- MOVE (1 cycle):
  - Latch `location_q`, `rotation_q` and `board_q` from `dp_*`.
  - Next state: LAND if `dp_touched` and `move`==0, else WAIT.
  - A touch during a sideways or rotate move does not land the piece.
- LAND (1 cycle): no register updates. Next state: CLEAR.
- CLEAR (1 cycle):
  - Add the number of full rows in `board_q` (0..8) to `score`, saturating at all-ones.
  - Latch `board_q`<=`dp_board`.
  - Next state: GEN.
- GAMEOVER:
  - `game_over`=1 and `btn_ready`=1.
  - An accepted request with `btn_move`==3 goes to NEWBOARD and clears `score`. Other codes are accepted and discarded.
- Outside MOVE, `move` is driven 0.
- `restart` overrides everything. The next state is NEWBOARD with all reset values, including mid-MOVE or mid-CLEAR.

## Timing
- Request accepted in WAIT cycle n:
  - `state`=MOVE in n+1.
  - Updated `location_q`/`board_q` visible in n+2, with `state`=WAIT.
- Gravity: with no requests, the first drop fires DROP_TICKS WAIT cycles after entering WAIT from GEN. Drops then repeat every DROP_TICKS+1 cycles (DROP_TICKS WAIT cycles plus 1 MOVE cycle).
- The drop counter pauses outside WAIT. It is not cleared by button moves.
- Landing to next spawn: MOVE(touch) → LAND → CLEAR → GEN → WAIT, 4 cycles.
- `old_state` always equals the previous cycle's `state`. In the first cycle after reset it equals NEWBOARD.

## Configuration
- `TETRIS_CTRL_SCORE_EN`:
  - Defined: row counting and the `score` register are built as described.
  - Undefined: `score` is tied to 0 and the row-count logic is omitted. CLEAR still lasts 1 cycle and the state sequence is unchanged.

## Test plan
- Reset: assert `restart` for 2 cycles.
  - Required: `state`=100, then 000, then 110.
  - Required: `location_q`=2, `rotation_q`=0, `score`=0, `game_over`=0.
- Gravity: DROP_TICKS=4, no requests, `dp_touched`=0.
  - Required: MOVE with `move`=0 after 4 WAIT cycles, then every 5 cycles.
  - Required: `location_q` follows `dp_location`.
- Request: `btn_valid`=1, `btn_move`=1 in a WAIT cycle.
  - Required: `btn_ready`=1 that cycle and MOVE next cycle with `move`=1.
  - Required: `dp_touched`=1 during that MOVE returns to WAIT, not LAND.
- Simultaneous: request on the cycle the counter reaches DROP_TICKS-1.
  - Required: button MOVE first, then a gravity MOVE after exactly 1 WAIT cycle.
- Land/clear: `board_q` with rows 6 and 7 full, gravity MOVE with `dp_touched`=1.
  - Required: LAND, then CLEAR, then GEN, and `score` increases by 2.
- Game over: `dp_error`=1 in GEN.
  - Required: GAMEOVER with `game_over`=1. `btn_move`=2 is ignored. `btn_move`=3 leads to NEWBOARD, `score`=0.

Source files
------------

// File: rtl/tetris_ctrl_if.sv
// Player request handshake between the button front end (master) and tetris_ctrl (slave).
interface tetris_ctrl_if;
    logic       btn_valid;
    logic [1:0] btn_move;
    logic       btn_ready;

    modport master (output btn_valid, output btn_move, input btn_ready);
    modport slave  (input btn_valid, input btn_move, output btn_ready);
endinterface

// File: rtl/tetris_ctrl.sv
// Tetris game sequencer: state register, registered board/piece feedback, gravity and score.
// Optional feature macro: TETRIS_CTRL_SCORE_EN builds the full-row counter and score register.
module tetris_ctrl #(
    parameter int DROP_TICKS = 16,
    parameter int SCORE_W    = 8
) (
    input  logic               clka,
    input  logic               restart,
    tetris_ctrl_if.slave       btn,
    output logic [2:0]         state,
    output logic [2:0]         old_state,
    output logic [1:0]         move,
    output logic [31:0]        board_q,
    output logic [1:0]         piece_q,
    output logic [4:0]         location_q,
    output logic [1:0]         rotation_q,
    input  logic [31:0]        dp_board,
    input  logic [1:0]         dp_piece,
    input  logic [4:0]         dp_location,
    input  logic [1:0]         dp_rotation,
    input  logic               dp_touched,
    input  logic               dp_error,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [2:0] {
        ST_GEN      = 3'b000,
        ST_MOVE     = 3'b001,
        ST_LAND     = 3'b010,
        ST_CLEAR    = 3'b011,
        ST_NEWBOARD = 3'b100,
        ST_GAMEOVER = 3'b101,
        ST_WAIT     = 3'b110
    } state_e;

    localparam logic [7:0] DROP_LAST = 8'(DROP_TICKS - 1);
    localparam logic [4:0] SPAWN_LOC = 5'd2;

    state_e      state_q, state_d;
    state_e      old_state_q;
    logic [1:0]  move_q, move_d;
    logic [31:0] board_d;
    logic [1:0]  piece_d;
    logic [4:0]  location_d;
    logic [1:0]  rotation_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        game_over_q, btn_ready_q;
    logic        btn_req;
    logic        new_game;

    // A zero code is not a request, in WAIT or in GAMEOVER.
    assign btn_req  = btn.btn_valid && (btn.btn_move != 2'd0);
    assign new_game = (state_q == ST_GAMEOVER) && btn_req && (btn.btn_move == 2'd3);

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        move_d     = 2'd0;
        board_d    = board_q;
        piece_d    = piece_q;
        location_d = location_q;
        rotation_d = rotation_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_NEWBOARD: begin
                board_d    = dp_board;
                piece_d    = 2'd0;
                location_d = SPAWN_LOC;
                rotation_d = 2'd0;
                state_d    = ST_GEN;
            end
            ST_GEN: begin
                board_d    = dp_board;
                piece_d    = dp_piece;
                location_d = SPAWN_LOC;
                rotation_d = 2'd0;
                drop_cnt_d = 8'd0;
                state_d    = dp_error ? ST_GAMEOVER : ST_WAIT;
            end
            ST_WAIT: begin
                // Button wins a tie with gravity; the counter holds so the drop fires next WAIT cycle.
                if (btn_req) begin
                    move_d  = btn.btn_move;
                    state_d = ST_MOVE;
                end else if (drop_cnt_q == DROP_LAST) begin
                    drop_cnt_d = 8'd0;
                    state_d    = ST_MOVE;
                end else begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            ST_MOVE: begin
                board_d    = dp_board;
                location_d = dp_location;
                rotation_d = dp_rotation;
                state_d    = (dp_touched && (move_q == 2'd0)) ? ST_LAND : ST_WAIT;
            end
            ST_LAND:  state_d = ST_CLEAR;
            ST_CLEAR: begin
                board_d = dp_board;
                state_d = ST_GEN;
            end
            ST_GAMEOVER: begin
                if (new_game) state_d = ST_NEWBOARD;
            end
            default: state_d = ST_NEWBOARD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clka) begin
        if (restart) begin
            state_q     <= ST_NEWBOARD;
            old_state_q <= ST_NEWBOARD;
            move_q      <= 2'd0;
            board_q     <= 32'd0;
            piece_q     <= 2'd0;
            location_q  <= SPAWN_LOC;
            rotation_q  <= 2'd0;
            drop_cnt_q  <= 8'd0;
            game_over_q <= 1'b0;
            btn_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            old_state_q <= state_q;
            move_q      <= move_d;
            board_q     <= board_d;
            piece_q     <= piece_d;
            location_q  <= location_d;
            rotation_q  <= rotation_d;
            drop_cnt_q  <= drop_cnt_d;
            game_over_q <= (state_d == ST_GAMEOVER);
            btn_ready_q <= (state_d == ST_WAIT) || (state_d == ST_GAMEOVER);
        end
    end

    assign state         = state_q;
    assign old_state     = old_state_q;
    assign move          = move_q;
    assign game_over     = game_over_q;
    assign btn.btn_ready = btn_ready_q;

`ifdef TETRIS_CTRL_SCORE_EN
    localparam int SUM_W = SCORE_W + 4;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         full_rows;
    logic [SUM_W-1:0]   score_sum;

    always_comb begin
        full_rows = 4'd0;
        for (int r = 0; r < 8; r++) begin
            full_rows = full_rows + {3'd0, &board_q[r*4 +: 4]};
        end
    end

    assign score_sum = SUM_W'(score_q) + SUM_W'(full_rows);

    always_comb begin
        score_d = score_q;
        if (new_game) begin
            score_d = '0;
        end else if (state_q == ST_CLEAR) begin
            score_d = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clka) begin
        if (restart) score_q <= '0;
        else         score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_tetris_ctrl.sv
// Directed bench for tetris_ctrl: reset, gravity, requests, tie-break, land/clear, game over, restart.
module tb_tetris_ctrl;

`ifdef TETRIS_CTRL_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    localparam logic [2:0] S_GEN = 3'b000, S_MOVE = 3'b001, S_LAND = 3'b010, S_CLEAR = 3'b011,
                           S_NEWBOARD = 3'b100, S_GAMEOVER = 3'b101, S_WAIT = 3'b110;

    logic        clka = 1'b0;
    logic        restart;
    logic [2:0]  state, old_state;
    logic [1:0]  move;
    logic [31:0] board_q;
    logic [1:0]  piece_q;
    logic [4:0]  location_q;
    logic [1:0]  rotation_q;
    logic [31:0] dp_board;
    logic [1:0]  dp_piece;
    logic [4:0]  dp_location;
    logic [1:0]  dp_rotation;
    logic        dp_touched, dp_error;
    logic        game_over;
    logic [7:0]  score;

    int n_checks = 0;
    int n_errors = 0;

    tetris_ctrl_if btn_if ();

    tetris_ctrl #(.DROP_TICKS(4), .SCORE_W(8)) dut (
        .clka       (clka),
        .restart    (restart),
        .btn        (btn_if.slave),
        .state      (state),
        .old_state  (old_state),
        .move       (move),
        .board_q    (board_q),
        .piece_q    (piece_q),
        .location_q (location_q),
        .rotation_q (rotation_q),
        .dp_board   (dp_board),
        .dp_piece   (dp_piece),
        .dp_location(dp_location),
        .dp_rotation(dp_rotation),
        .dp_touched (dp_touched),
        .dp_error   (dp_error),
        .game_over  (game_over),
        .score      (score)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    initial begin
        restart          = 1'b1;
        btn_if.btn_valid = 1'b0;
        btn_if.btn_move  = 2'd0;
        dp_board         = 32'h0000_0000;
        dp_piece         = 2'd0;
        dp_location      = 5'd2;
        dp_rotation      = 2'd0;
        dp_touched       = 1'b0;
        dp_error         = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_state", state, S_NEWBOARD);
        check("rst_old_state", old_state, S_NEWBOARD);
        check("rst_location", location_q, 5'd2);
        check("rst_rotation", rotation_q, 2'd0);
        check("rst_move", move, 2'd0);
        check("rst_score", score, 8'd0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_btn_ready", btn_if.btn_ready, 1'b0);

        restart     = 1'b0;
        dp_board    = 32'h0000_0001;
        tick();
        check("newboard_to_gen", state, S_GEN);
        check("gen_old_state", old_state, S_NEWBOARD);
        check("newboard_board", board_q, 32'h0000_0001);

        dp_piece = 2'd3;
        tick();
        check("gen_to_wait", state, S_WAIT);
        check("wait_old_state", old_state, S_GEN);
        check("gen_piece", piece_q, 2'd3);
        check("wait_btn_ready", btn_if.btn_ready, 1'b1);

        // Gravity: three more WAIT cycles, then MOVE with move=0.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("grav1_wait", state, S_WAIT);
        end
        dp_location = 5'd6;
        tick();
        check("grav1_move", state, S_MOVE);
        check("grav1_move_code", move, 2'd0);
        tick();
        check("grav1_back_wait", state, S_WAIT);
        check("grav1_location", location_q, 5'd6);
        check("grav1_move_zero", move, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("grav2_wait", state, S_WAIT);
        end
        dp_location = 5'd10;
        tick();
        check("grav2_move_period5", state, S_MOVE);
        tick();
        check("grav2_location", location_q, 5'd10);

        // Left request in the first WAIT cycle; touch during it must not land.
        check("req_btn_ready", btn_if.btn_ready, 1'b1);
        btn_if.btn_valid = 1'b1;
        btn_if.btn_move  = 2'd1;
        tick();
        check("req_move_state", state, S_MOVE);
        check("req_move_code", move, 2'd1);
        btn_if.btn_valid = 1'b0;
        btn_if.btn_move  = 2'd0;
        dp_touched       = 1'b1;
        dp_location      = 5'd9;
        tick();
        check("req_touch_no_land", state, S_WAIT);
        check("req_location", location_q, 5'd9);
        dp_touched = 1'b0;

        // Counter is 0 again; walk it to DROP_TICKS-1 and request on that cycle.
        tick();
        tick();
        tick();
        check("tie_wait", state, S_WAIT);
        btn_if.btn_valid = 1'b1;
        btn_if.btn_move  = 2'd2;
        tick();
        check("tie_btn_first", state, S_MOVE);
        check("tie_btn_code", move, 2'd2);
        btn_if.btn_valid = 1'b0;
        btn_if.btn_move  = 2'd0;
        tick();
        check("tie_one_wait", state, S_WAIT);
        dp_board   = 32'hFF00_0010;
        dp_touched = 1'b1;
        tick();
        check("tie_gravity_move", state, S_MOVE);
        check("tie_gravity_code", move, 2'd0);

        // Gravity touch lands: rows 6 and 7 full.
        tick();
        check("land_state", state, S_LAND);
        check("land_old_state", old_state, S_MOVE);
        check("land_board", board_q, 32'hFF00_0010);
        dp_touched = 1'b0;
        dp_board   = 32'h0000_0010;
        tick();
        check("clear_state", state, S_CLEAR);
        check("land_no_update", board_q, 32'hFF00_0010);
        dp_error = 1'b1;
        tick();
        check("clear_to_gen", state, S_GEN);
        check("clear_board", board_q, 32'h0000_0010);
        check("clear_score", score, SCORE_EN ? 8'd2 : 8'd0);

        // Spawn collision ends the game.
        tick();
        check("gameover_state", state, S_GAMEOVER);
        check("gameover_flag", game_over, 1'b1);
        check("gameover_ready", btn_if.btn_ready, 1'b1);
        dp_error         = 1'b0;
        btn_if.btn_valid = 1'b1;
        btn_if.btn_move  = 2'd2;
        tick();
        check("gameover_ignore_right", state, S_GAMEOVER);
        check("gameover_keep_score", score, SCORE_EN ? 8'd2 : 8'd0);
        btn_if.btn_move = 2'd3;
        tick();
        check("gameover_rotate_newboard", state, S_NEWBOARD);
        check("gameover_score_clear", score, 8'd0);
        check("gameover_flag_drop", game_over, 1'b0);
        btn_if.btn_valid = 1'b0;
        btn_if.btn_move  = 2'd0;
        tick();
        check("restart_game_gen", state, S_GEN);
        tick();
        check("restart_game_wait", state, S_WAIT);

        // Restart during a MOVE cycle.
        btn_if.btn_valid = 1'b1;
        btn_if.btn_move  = 2'd3;
        dp_location      = 5'd17;
        tick();
        check("pre_rst_move", move, 2'd3);
        restart          = 1'b1;
        btn_if.btn_valid = 1'b0;
        btn_if.btn_move  = 2'd0;
        tick();
        check("mid_move_rst_state", state, S_NEWBOARD);
        check("mid_move_rst_old", old_state, S_NEWBOARD);
        check("mid_move_rst_loc", location_q, 5'd2);
        check("mid_move_rst_move", move, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
